// File: rtl/z1_top_if.sv
// Board-level I/O bundle of the FM synthesizer top: buttons, switches, LEDs, UART and audio pins.
interface z1_top_if;
  logic [3:0] BUTTONS;
  logic [1:0] SWITCHES;
  logic [5:0] LEDS;
  logic       FPGA_SERIAL_RX;
  logic       FPGA_SERIAL_TX;
  logic       AUD_PWM;
  logic       AUD_SD;

  modport master (
    output BUTTONS, SWITCHES, FPGA_SERIAL_RX,
    input  LEDS, FPGA_SERIAL_TX, AUD_PWM, AUD_SD
  );

  modport slave (
    input  BUTTONS, SWITCHES, FPGA_SERIAL_RX,
    output LEDS, FPGA_SERIAL_TX, AUD_PWM, AUD_SD
  );
endinterface

// File: rtl/z1_top.sv
// UART-controlled polyphonic FM square-wave synthesizer: UART RX, command decoder,
// modulator/carrier NCO bank, saturating mixer and 10-bit PWM audio DAC.
module z1_top #(
  parameter int unsigned CLOCK_FREQ            = 125_000_000,
  parameter int unsigned BAUD_RATE             = 115_200,
  parameter int unsigned N_VOICES              = 4,
  parameter int unsigned B_SAMPLE_CNT_MAX      = 62500,
  parameter int unsigned B_PULSE_CNT_MAX       = 200,
  parameter int unsigned CPU_CLOCK_FREQ        = 50_000_000,
  parameter int unsigned CPU_CLK_CLKFBOUT_MULT = 8,
  parameter int unsigned CPU_CLK_DIVCLK_DIVIDE = 1,
  parameter int unsigned CPU_CLK_CLKOUT_DIVIDE = 20,
  parameter logic [31:0] RESET_PC              = 32'h4000_0000
) (
  input logic     CLK_125MHZ_FPGA,
  input logic     RESET_N,
  z1_top_if.slave io
);

  localparam int unsigned SYMBOL_EDGE = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_EDGE   = SYMBOL_EDGE / 2;
  localparam int unsigned BAUD_W      = $clog2(SYMBOL_EDGE + 1);
  localparam int unsigned BS_W        = $clog2(B_SAMPLE_CNT_MAX + 1);
  localparam int unsigned BP_W        = $clog2(B_PULSE_CNT_MAX + 1);
  localparam int unsigned VI_W        = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int unsigned SUM_W       = 11 + VI_W;
  localparam int unsigned LED_N       = (N_VOICES < 6) ? N_VOICES : 6;
  localparam int unsigned FCW_W       = 24 * N_VOICES;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARG0 = 3'd1;
  localparam logic [2:0] S_ARG1 = 3'd2;
  localparam logic [2:0] S_ARG2 = 3'd3;
  localparam logic [2:0] S_EXEC = 3'd4;

  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(511);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-512);

  logic clk;
  logic rst_n;
  assign clk   = CLK_125MHZ_FPGA;
  assign rst_n = RESET_N;

  logic unused_inputs;
  assign unused_inputs = ^{io.SWITCHES, io.BUTTONS[3:1]};

  // Input synchronizers and RX edge detect
  logic [1:0] rx_sync_q, btn_sync_q;
  logic       rx_prev_q;
  logic       rx_s, rx_fall;
  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= 2'b11;
      btn_sync_q <= 2'b00;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], io.FPGA_SERIAL_RX};
      btn_sync_q <= {btn_sync_q[0], io.BUTTONS[0]};
      rx_prev_q  <= rx_s;
    end
  end

  // Soft-reset button debouncer; soft_rst_q pulses once per press
  logic [BS_W-1:0] bs_cnt_q;
  logic [BP_W-1:0] bp_cnt_q;
  logic            pressed_q, soft_rst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bs_cnt_q   <= '0;
      bp_cnt_q   <= '0;
      pressed_q  <= 1'b0;
      soft_rst_q <= 1'b0;
    end else begin
      if (bs_cnt_q == BS_W'(B_SAMPLE_CNT_MAX - 1)) begin
        bs_cnt_q <= '0;
        if (!btn_sync_q[1])                          bp_cnt_q <= '0;
        else if (bp_cnt_q != BP_W'(B_PULSE_CNT_MAX)) bp_cnt_q <= bp_cnt_q + BP_W'(1);
      end else begin
        bs_cnt_q <= bs_cnt_q + BS_W'(1);
      end
      pressed_q  <= (bp_cnt_q == BP_W'(B_PULSE_CNT_MAX));
      soft_rst_q <= (bp_cnt_q == BP_W'(B_PULSE_CNT_MAX)) && !pressed_q;
    end
  end

  // UART receiver, 8N1 LSB first
  logic [1:0]        rx_st_q, rx_st_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d, rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q    <= RX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    baud_d     = baud_q + BAUD_W'(1);
    bit_d      = bit_q;
    sh_d       = sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        baud_d = '0;
        if (rx_fall) rx_st_d = RX_START;
      end
      RX_START: if (baud_q == BAUD_W'(HALF_EDGE - 1)) begin
        baud_d  = '0;
        bit_d   = '0;
        rx_st_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (baud_q == BAUD_W'(SYMBOL_EDGE - 1)) begin
        baud_d = '0;
        sh_d   = {rx_s, sh_q[7:1]};
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      default: if (baud_q == BAUD_W'(SYMBOL_EDGE - 1)) begin
        rx_st_d = RX_IDLE;
        if (rx_s) begin
          rx_valid_d = 1'b1;
          rx_data_d  = sh_q;
        end
      end
    endcase
  end

  // Command decoder and synth control registers
  logic [2:0]       state_q, state_d, op_q, op_d;
  logic [23:0]      arg_q, arg_d, mod_fcw_q, mod_fcw_d;
  logic [4:0]       mod_shift_q, mod_shift_d, syn_shift_q, syn_shift_d;
  logic [FCW_W-1:0] fcws_q, fcws_d;
  logic [N_VOICES-1:0] en_q, en_d;
  logic             note_hit_c;

  logic [23:0]         synth_mod_fcw;
  logic [4:0]          synth_mod_shift, synth_synth_shift;
  logic [FCW_W-1:0]    synth_carrier_fcws;
  logic [N_VOICES-1:0] synth_note_en;
  assign synth_mod_fcw      = mod_fcw_q;
  assign synth_mod_shift    = mod_shift_q;
  assign synth_synth_shift  = syn_shift_q;
  assign synth_carrier_fcws = fcws_q;
  assign synth_note_en      = en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      arg_q       <= '0;
      mod_fcw_q   <= '0;
      mod_shift_q <= '0;
      syn_shift_q <= '0;
      fcws_q      <= '0;
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      mod_fcw_q   <= mod_fcw_d;
      mod_shift_q <= mod_shift_d;
      syn_shift_q <= syn_shift_d;
      fcws_q      <= fcws_d;
      en_q        <= en_d;
    end
  end

  always_comb begin
    note_hit_c = 1'b0;
    for (int k = 0; k < int'(N_VOICES); k++)
      if (en_q[k] && (fcws_q[24*k +: 24] == arg_q)) note_hit_c = 1'b1;
  end

  always_comb begin
    logic taken;
    taken       = 1'b0;
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    mod_fcw_d   = mod_fcw_q;
    mod_shift_d = mod_shift_q;
    syn_shift_d = syn_shift_q;
    fcws_d      = fcws_q;
    en_d        = en_q;
    case (state_q)
      S_IDLE: if (rx_valid_q && rx_data_q >= 8'd1 && rx_data_q <= 8'd5) begin
        op_d    = rx_data_q[2:0];
        state_d = S_ARG0;
      end
      S_ARG0: if (rx_valid_q) begin
        arg_d[7:0] = rx_data_q;
        state_d    = (op_q == 3'd2 || op_q == 3'd5) ? S_EXEC : S_ARG1;
      end
      S_ARG1: if (rx_valid_q) begin
        arg_d[15:8] = rx_data_q;
        state_d     = S_ARG2;
      end
      S_ARG2: if (rx_valid_q) begin
        arg_d[23:16] = rx_data_q;
        state_d      = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (op_q)
          3'd1: mod_fcw_d   = arg_q;
          3'd2: mod_shift_d = arg_q[4:0];
          3'd5: syn_shift_d = arg_q[4:0];
          // Note on: an already-sounding match wins, else the lowest free voice
          3'd3: if (!note_hit_c) begin
            for (int k = 0; k < int'(N_VOICES); k++)
              if (!taken && !en_q[k]) begin
                taken              = 1'b1;
                fcws_d[24*k +: 24] = arg_q;
                en_d[k]            = 1'b1;
              end
          end
          3'd4: begin
            for (int k = 0; k < int'(N_VOICES); k++)
              if (fcws_q[24*k +: 24] == arg_q) en_d[k] = 1'b0;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    if (soft_rst_q) begin
      state_d     = S_IDLE;
      op_d        = '0;
      arg_d       = '0;
      mod_fcw_d   = '0;
      mod_shift_d = '0;
      syn_shift_d = '0;
      fcws_d      = '0;
      en_d        = '0;
    end
  end

  // NCO bank: modulator plus per-voice carriers advanced once per sample tick
  logic [10:0]         tick_cnt_q;
  logic [23:0]         mp_q;
  logic [FCW_W-1:0]    ph_q;
  logic [N_VOICES-1:0] en_prev_q;
  logic                tick_c;
  logic [9:0]          m_c;
  logic [23:0]         mod_term_c;

  assign tick_c     = (tick_cnt_q == 11'h7FF);
  assign m_c        = mp_q[23] ? 10'h200 : 10'h1FF;
  assign mod_term_c = {{14{m_c[9]}}, m_c} << synth_mod_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      mp_q       <= '0;
      ph_q       <= '0;
      en_prev_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 11'd1;
      if (tick_c) mp_q <= mp_q + synth_mod_fcw;
      for (int k = 0; k < int'(N_VOICES); k++) begin
        if (synth_note_en[k] && !en_prev_q[k])
          ph_q[24*k +: 24] <= '0;
        else if (synth_note_en[k] && tick_c)
          ph_q[24*k +: 24] <= ph_q[24*k +: 24] + synth_carrier_fcws[24*k +: 24] + mod_term_c;
      end
      en_prev_q <= synth_note_en;
    end
  end

  // Mixer: signed sum, arithmetic shift, saturate, offset to unsigned code
  logic signed [SUM_W-1:0] sum_c, mix_c;
  logic [9:0]              code_c;

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < int'(N_VOICES); k++)
      if (synth_note_en[k]) sum_c = sum_c + (ph_q[24*k+23] ? SAT_LO : SAT_HI);
    mix_c = sum_c >>> synth_synth_shift;
    if (mix_c > SAT_HI)      code_c = 10'd1023;
    else if (mix_c < SAT_LO) code_c = 10'd0;
    else                     code_c = 10'(mix_c - SAT_LO);
  end

  // PWM DAC and registered board outputs
  logic [9:0] code_tick_q, pwm_code_q, pwm_cnt_q;
  logic       pwm_q, pwm_rst_q, aud_sd_q;
  logic [5:0] leds_q;
  logic       pwm_rst;
  assign pwm_rst = pwm_rst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_tick_q <= 10'd512;
      pwm_code_q  <= 10'd512;
      pwm_cnt_q   <= '0;
      pwm_q       <= 1'b0;
      pwm_rst_q   <= 1'b1;
      aud_sd_q    <= 1'b0;
      leds_q      <= '0;
    end else begin
      if (tick_c) code_tick_q <= code_c;
      if (pwm_cnt_q == 10'd1023) pwm_code_q <= code_tick_q;
      pwm_cnt_q <= pwm_cnt_q + 10'd1;
      pwm_q     <= !pwm_rst_q && (pwm_cnt_q < pwm_code_q);
      pwm_rst_q <= 1'b0;
      aud_sd_q  <= 1'b1;
      leds_q    <= 6'(synth_note_en[LED_N-1:0]);
    end
  end

  assign io.LEDS           = leds_q;
  assign io.FPGA_SERIAL_TX = 1'b1;
  assign io.AUD_PWM        = pwm_q;
  assign io.AUD_SD         = aud_sd_q;

endmodule

// File: tb/tb_z1_top.sv
// Scoreboard bench for z1_top: commands push expected register snapshots, a monitor checks each EXEC.
module tb_z1_top;

  localparam int BIT = 12;  // 125 MHz / 10 MBd

  typedef struct packed {
    logic [23:0] mod_fcw;
    logic [4:0]  mod_shift;
    logic [4:0]  syn_shift;
    logic [95:0] fcws;
    logic [3:0]  en;
  } regs_t;

  logic clk;
  logic rst_n;
  z1_top_if bus();

  z1_top #(
    .BAUD_RATE(10_000_000),
    .B_SAMPLE_CNT_MAX(5),
    .B_PULSE_CNT_MAX(5)
  ) dut (
    .CLK_125MHZ_FPGA(clk),
    .RESET_N(rst_n),
    .io(bus)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  regs_t exp_q[$];
  regs_t model;

  function automatic regs_t snap();
    regs_t r;
    r.mod_fcw   = dut.synth_mod_fcw;
    r.mod_shift = dut.synth_mod_shift;
    r.syn_shift = dut.synth_synth_shift;
    r.fcws      = dut.synth_carrier_fcws;
    r.en        = dut.synth_note_en;
    return r;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: each EXEC cycle must match the oldest expected snapshot
  initial begin
    regs_t act, e;
    forever begin
      @(negedge clk);
      if (dut.state_q == 3'd4) begin
        @(negedge clk);
        act = snap();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL exec_unexpected actual=%0h", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL exec_regs actual=%0h expected=%0h", act, e);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.FPGA_SERIAL_RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.FPGA_SERIAL_RX = b[i];
      repeat (BIT) @(negedge clk);
    end
    bus.FPGA_SERIAL_RX = stop;
    repeat (BIT) @(negedge clk);
    bus.FPGA_SERIAL_RX = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout actual=%0d pending expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic cmd1(input string name, input logic [7:0] op, input logic [7:0] b);
    exp_q.push_back(model);
    send_byte(op, 1'b1);
    send_byte(b, 1'b1);
    wait_drain(name);
  endtask

  task automatic cmd3(input string name, input logic [7:0] op, input logic [23:0] f);
    exp_q.push_back(model);
    send_byte(op, 1'b1);
    send_byte(f[7:0], 1'b1);
    send_byte(f[15:8], 1'b1);
    send_byte(f[23:16], 1'b1);
    wait_drain(name);
  endtask

  initial begin
    #700_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int hi;
    rst_n              = 1'b0;
    bus.BUTTONS        = 4'b0000;
    bus.SWITCHES       = 2'b00;
    bus.FPGA_SERIAL_RX = 1'b1;
    model              = '0;
    repeat (5) @(negedge clk);

    check("rst_pwm_rst", 160'(dut.pwm_rst), 160'(1));
    check("rst_aud_sd",  160'(bus.AUD_SD), 160'(0));
    check("rst_aud_pwm", 160'(bus.AUD_PWM), 160'(0));
    check("rst_leds",    160'(bus.LEDS), 160'(0));
    check("rst_tx",      160'(bus.FPGA_SERIAL_TX), 160'(1));

    rst_n = 1'b1;
    @(negedge clk);
    check("pwm_rst_release", 160'(dut.pwm_rst), 160'(0));
    @(negedge clk);
    check("aud_sd_on", 160'(bus.AUD_SD), 160'(1));
    check("regs_after_reset", 160'(snap()), 160'(0));

    // Idle mid-scale code: half duty over two PWM periods
    hi = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (bus.AUD_PWM) hi++;
    end
    n_cmp++;
    if (hi < 1020 || hi > 1028) begin
      n_err++;
      $display("FAIL idle_pwm_duty actual=%0d expected=1024", hi);
    end

    model.mod_shift = 5'd8;               cmd1("mod_shift", 8'h02, 8'h08);
    model.syn_shift = 5'd2;               cmd1("syn_shift", 8'h05, 8'h02);
    model.mod_fcw   = 24'd1118481;        cmd3("mod_fcw", 8'h01, 24'h111111);
    model.fcws[23:0] = 24'd2796202; model.en[0] = 1'b1;
    cmd3("note_on_v0", 8'h03, 24'd2796202);
    model.fcws[47:24] = 24'd1006202; model.en[1] = 1'b1;
    cmd3("note_on_v1", 8'h03, 24'd1006202);
    repeat (3) @(negedge clk);
    check("leds_two", 160'(bus.LEDS[1:0]), 160'(2'b11));

    model.en[0] = 1'b0;                   cmd3("note_off_v0", 8'h04, 24'd2796202);
    model.en[0] = 1'b1;                   cmd3("note_reuse_v0", 8'h03, 24'd2796202);
    model.fcws[71:48] = 24'h000100; model.en[2] = 1'b1;
    cmd3("note_on_v2", 8'h03, 24'h000100);
    cmd3("note_dup", 8'h03, 24'h000100);
    model.fcws[95:72] = 24'h000200; model.en[3] = 1'b1;
    cmd3("note_on_v3", 8'h03, 24'h000200);
    cmd3("note_full", 8'h03, 24'h000300);

    send_byte(8'h02, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    model.syn_shift = 5'd3;               cmd1("after_bad_stop", 8'h05, 8'h03);
    send_byte(8'h07, 1'b1);
    model.syn_shift = 5'd1;               cmd1("after_bad_op", 8'h05, 8'h01);
    repeat (3) @(negedge clk);
    check("leds_four", 160'(bus.LEDS), 160'(6'b001111));

    bus.BUTTONS[0] = 1'b1;
    repeat (50) @(negedge clk);
    bus.BUTTONS[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("soft_rst_regs", 160'(snap()), 160'(0));
    check("soft_rst_leds", 160'(bus.LEDS), 160'(0));
    check("soft_rst_state", 160'(dut.state_q), 160'(0));
    check("queue_empty", 160'(exp_q.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/z1_top.md
Name: z1_top

Overview:
- FPGA top-level for a UART-controlled polyphonic FM square-wave synthesizer.
- A UART receiver feeds a hardware command decoder. The decoder writes synth control registers: modulator FCW and shift, mixer shift, and per-voice carrier FCW and enable.
- An NCO bank generates samples, which drive a 10-bit PWM audio DAC.
- Everything runs on the 125 MHz board clock; there is no PLL and no CPU.

Parameters:
- CLOCK_FREQ, 125_000_000, board clock in Hz; sets the UART bit period.
- BAUD_RATE, 115_200, UART baud; SYMBOL_EDGE = CLOCK_FREQ/BAUD_RATE.
- N_VOICES, 4, number of carriers (1..8).
- B_SAMPLE_CNT_MAX, 62500, button sampling period in cycles.
- B_PULSE_CNT_MAX, 200, consecutive high samples required to register a press.
- CPU_CLOCK_FREQ, CPU_CLK_CLKFBOUT_MULT, CPU_CLK_DIVCLK_DIVIDE, CPU_CLK_CLKOUT_DIVIDE, RESET_PC: interface-compatibility only; no effect.

Ports:
- CLK_125MHZ_FPGA  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- BUTTONS  in  4  raw push buttons; BUTTONS[0] is a soft reset, the others are unused.
- SWITCHES  in  2  unused.
- LEDS  out  6  LEDS[k] = synth_note_en[k] for k < min(N_VOICES,6); other bits 0.
- FPGA_SERIAL_RX  in  1  UART receive line, idle high.
- FPGA_SERIAL_TX  out  1  held at 1.
- AUD_PWM  out  1  PWM audio.
- AUD_SD  out  1  amplifier enable.

Behaviour:
- Reset:
  - RESET_N low asynchronously clears all state. After reset: AUD_PWM=0, AUD_SD=0, LEDS=0, FPGA_SERIAL_TX=1.
  - Internal signal pwm_rst is 1 during reset and deasserts on the first clock edge after RESET_N goes high. AUD_SD = ~pwm_rst.
- Soft reset:
  - BUTTONS[0] is debounced: sampled every B_SAMPLE_CNT_MAX cycles; counts as pressed after B_PULSE_CNT_MAX consecutive high samples.
  - A rising-edge pulse of the pressed state clears the command FSM and all synth registers, exactly as reset does.
- UART RX (8N1, LSB first):
  - Falling edge starts a frame; the start bit is re-checked at mid-bit and a glitch aborts the frame.
  - Data bits are sampled at mid-bit. A stop bit of 0 drops the byte.
  - A valid byte produces a 1-cycle data_valid.
- Command FSM, states IDLE, ARG0, ARG1, ARG2, EXEC:
  - 0x01 b0 b1 b2: synth_mod_fcw = {b2,b1,b0}.
  - 0x02 b: synth_mod_shift = b[4:0].
  - 0x03 b0 b1 b2 (note on), f={b2,b1,b0}:
    - If a voice already has en=1 and fcw==f, no change.
    - Otherwise the lowest-index voice with en=0 gets fcw=f, en=1.
    - If all voices are enabled, the command is ignored.
  - 0x04 b0 b1 b2 (note off): every voice with fcw==f gets en=0; its fcw is kept.
  - 0x05 b: synth_synth_shift = b[4:0].
  - Any other opcode is ignored; the FSM stays in IDLE.
  - Registers update ≤2 cycles after the last byte's data_valid.
- Synth register signal names:
  - synth_mod_fcw[23:0], synth_mod_shift[4:0], synth_synth_shift[4:0].
  - synth_carrier_fcws[24*N_VOICES-1:0], with voice k at [24k+23:24k].
  - synth_note_en[N_VOICES-1:0].
  - Reset value of all of these is 0.
- Sample tick: once every 2048 cycles (≈61 kHz).
- Modulator:
  - 24-bit phase accumulator, mp += synth_mod_fcw mod 2^24 per tick.
  - m = mp[23] ? -512 : +511.
- Carrier k:
  - Runs only while en[k]=1; its phase is cleared to 0 when en[k] rises.
  - Per tick: ph_k += fcw_k + (sext(m) << synth_mod_shift), mod 2^24.
  - s_k = ph_k[23] ? -512 : +511; s_k = 0 when disabled.
- Mixer:
  - sum = Σ s_k, signed, width ≥ 10+log2(N_VOICES).
  - mix = sum >>> synth_synth_shift (arithmetic shift).
  - Saturate mix to [-512,511].
  - code = mix + 512, giving 0..1023.
- PWM:
  - 10-bit free-running counter.
  - code is latched when the counter wraps to 0.
  - AUD_PWM is registered: 1 while counter < code.
  - code=0 gives a constant 0; code=1023 gives 1023 of every 1024 cycles high.
  - Before the first sample tick code=512, but AUD_PWM=0 while pwm_rst.

Test Plan:
- Reset then idle → pwm_rst=0 one cycle after RESET_N high; all synth registers 0; AUD_SD=1; with no voices active, the average AUD_PWM over 2048 cycles ≈ 0.5.
- BAUD_RATE=10_000_000. Send 0x02,0x08 → synth_mod_shift==8. Send 0x05,0x02 → synth_synth_shift==2.
- Send 0x01,0x11,0x11,0x11 → synth_mod_fcw==24'd1118481.
- Send 0x03 with fcw 2796202 → synth_carrier_fcws[23:0]==2796202, synth_note_en[0]=1. Then 0x03 with fcw 1006202 → voice 1 holds 1006202, synth_note_en[1]=1, LEDS[1:0]=2'b11.
- Send 0x04 with fcw 2796202 → synth_note_en[0]=0, voice 1 still enabled. Send 0x03 with 2796202 again → it reuses voice 0.
- Negative cases:
  - Fill all 4 voices, then a 5th note-on → no change.
  - A frame with stop bit 0 → ignored.
  - A 0x07 byte → ignored, and the following valid command still works.
  - A BUTTONS[0] press held 50 cycles (B_*=5) → all synth registers cleared.
